// File: rtl/skewed_stream_ram.sv
// Multi-lane line RAM with a per-lane write port and a burst read engine. It can skew lanes
// diagonally so that lane k lags lane 0 by k cycles, which is how a systolic array edge expects data.

module skew_lane #(
  parameter int W   = 8,
  parameter int DLY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  if (DLY == 0) begin : g_nodly
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dout <= '0;
      else        dout <= din;
  end else begin : g_dly
    logic [DLY-1:0][W-1:0] dly;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        dly  <= '0;
        dout <= '0;
      end else begin
        dly[0] <= din;
        for (int m = 1; m < DLY; m++) dly[m] <= dly[m-1];
        dout <= dly[DLY-1];
      end
  end
endmodule

module skewed_stream_ram #(
  parameter int    LANES      = 3,
  parameter int    LANE_W     = 8,
  parameter int    ADDR_WIDTH = 4,
  parameter int    SKEW_EN    = 1,
  parameter string MEM_FILE   = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [LANES-1:0]        wr_lane_en,
  input  logic [LANES*LANE_W-1:0] wr_data,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     len,
  output logic                    busy,
  output logic                    out_valid,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    out_last,
  output logic                    done
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int STAGES = (SKEW_EN != 0) ? LANES - 1 : 0;
  localparam logic [ADDR_WIDTH:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                       state, state_nxt;
  logic [ADDR_WIDTH-1:0]        addr_q;
  logic [ADDR_WIDTH:0]          cnt_q;
  logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];
  logic [LANES-1:0][LANE_W-1:0] wdat, rd_q, rd_m, lane_out;
  logic [STAGES:0]              vld_pipe, last_pipe;
  logic                         out_valid_q, out_last_q;
  logic                         accept;

  assign wdat   = wr_data;
  assign accept = (state == IDLE) && start && (len != '0);

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    if (cnt_q == ONE) state_nxt = DRAIN;
      DRAIN:   if (out_last_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= base_addr;
        cnt_q  <= len;
      end else if (state == READ) begin
        addr_q <= addr_q + 1'b1;   // wraps naturally modulo depth
        cnt_q  <= cnt_q - 1'b1;
      end
    end

  // Memory is deliberately not reset; read-before-write on address collision.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++)
      if (wr_en && wr_lane_en[k]) mem[wr_addr][k] <= wdat[k];
    rd_q <= mem[addr_q];
  end

  assign rd_m = vld_pipe[0] ? rd_q : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe    <= '0;
      last_pipe   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      vld_pipe[0]  <= (state == READ);
      last_pipe[0] <= (state == READ) && (cnt_q == ONE);
      for (int m = 1; m <= STAGES; m++) begin
        vld_pipe[m]  <= vld_pipe[m-1];
        last_pipe[m] <= last_pipe[m-1];
      end
      // valid while any lane still carries a line; last when the final line leaves the slowest lane
      out_valid_q <= |vld_pipe;
      out_last_q  <= last_pipe[STAGES];
    end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_lane #(.W(LANE_W), .DLY((SKEW_EN != 0) ? k : 0)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (rd_m[k]),
      .dout (lane_out[k])
    );
  end

  assign out_data  = lane_out;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = out_last_q;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_skewed_stream_ram.sv
// Bench for skewed_stream_ram: a skewed and an aligned instance share one stimulus stream and are
// checked each cycle against an array model of the RAM and the burst/skew timing rules.
module tb_skewed_stream_ram;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [2:0]  wr_lane_en = '0;
  logic [23:0] wr_data = '0;
  logic        start = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  len = '0;
  logic        busy_s, valid_s, last_s, done_s, busy_a, valid_a, last_a, done_a;
  logic [23:0] data_s, data_a;

  int checks = 0;
  int errors = 0;
  logic [23:0] m [16];
  logic [27:0] a_c2;

  always #5 clk = ~clk;

  skewed_stream_ram #(.LANES(3), .LANE_W(8), .ADDR_WIDTH(4), .SKEW_EN(1)) u_sk (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en),
    .wr_data(wr_data), .start(start), .base_addr(base_addr), .len(len), .busy(busy_s),
    .out_valid(valid_s), .out_data(data_s), .out_last(last_s), .done(done_s));

  skewed_stream_ram #(.LANES(3), .LANE_W(8), .ADDR_WIDTH(4), .SKEW_EN(0)) u_al (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_en(wr_lane_en),
    .wr_data(wr_data), .start(start), .base_addr(base_addr), .len(len), .busy(busy_a),
    .out_valid(valid_a), .out_data(data_a), .out_last(last_a), .done(done_a));

  typedef struct { int c; logic [27:0] exp; } vec_t;
  vec_t t1 [9];

  function automatic logic [27:0] mk(logic b, logic v, logic l, logic [23:0] d);
    return {b, v, l, l, d};
  endfunction

  function automatic logic [27:0] act_s();
    return {busy_s, valid_s, last_s, done_s, data_s};
  endfunction

  function automatic logic [27:0] act_a();
    return {busy_a, valid_a, last_a, done_a, data_a};
  endfunction

  // Expected sample c negedges after the accepting edge, from the skew rule on model memory.
  function automatic logic [27:0] expv(int sk, int c, int base, int n);
    int nv, j, i;
    logic [23:0] d;
    nv = sk ? n + 2 : n;
    d = '0;
    j = c - 2;
    if (c >= 2 && c < 2 + nv)
      for (int k = 0; k < 3; k++) begin
        i = sk ? j - k : j;
        if (i >= 0 && i < n) d[k*8 +: 8] = m[(base + i) % 16][k*8 +: 8];
      end
    return mk(c < 2 + nv, c >= 2 && c < 2 + nv, c == nv + 1, d);
  endfunction

  task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic do_wr(input int a, input logic [2:0] le, input logic [23:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(a); wr_lane_en = le; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0; wr_lane_en = '0;
    for (int k = 0; k < 3; k++) if (le[k]) m[a][k*8 +: 8] = d[k*8 +: 8];
  endtask

  task automatic start_b(input int base, input int n);
    @(negedge clk);
    start = 1'b1; base_addr = 4'(base); len = 5'(n);
    @(posedge clk);
  endtask

  // mode 1: extra start while busy; mode 2: write line base+2 on the edge that reads it
  task automatic run_burst(input int base, input int n, input int mode);
    logic [23:0] wd;
    int wa;
    wd = 24'($urandom);
    wa = (base + 2) % 16;
    start_b(base, n);
    for (int c = 0; c <= n + 4; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      chk("burst_skew", act_s(), expv(1, c, base, n));
      chk("burst_align", act_a(), expv(0, c, base, n));
      if (c == 2) a_c2 = act_a();
      if (mode == 1 && c == 1) begin start = 1'b1; base_addr = 4'(base + 7); len = 5'd2; end
      if (mode == 1 && c == 2) start = 1'b0;
      if (mode == 2 && c == 2) begin
        wr_en = 1'b1; wr_addr = 4'(wa); wr_lane_en = 3'b111; wr_data = wd;
      end
      if (mode == 2 && c == 3) begin wr_en = 1'b0; wr_lane_en = '0; end
    end
    if (mode == 2) m[wa] = wd;
  endtask

  initial begin
    t1[0] = '{0, mk(1, 0, 0, 24'h000000)};
    t1[1] = '{1, mk(1, 0, 0, 24'h000000)};
    t1[2] = '{2, mk(1, 1, 0, 24'h000001)};
    t1[3] = '{3, mk(1, 1, 0, 24'h000204)};
    t1[4] = '{4, mk(1, 1, 0, 24'h030507)};
    t1[5] = '{5, mk(1, 1, 0, 24'h06080A)};
    t1[6] = '{6, mk(1, 1, 0, 24'h090B00)};
    t1[7] = '{7, mk(1, 1, 1, 24'h0C0000)};
    t1[8] = '{8, mk(0, 0, 0, 24'h000000)};
    for (int a = 0; a < 16; a++) m[a] = '0;

    #12;
    chk("reset_skew", act_s(), '0);
    chk("reset_align", act_a(), '0);
    @(negedge clk); rst_n = 1'b1;
    for (int a = 0; a < 16; a++) do_wr(a, 3'b111, 24'($urandom));

    // basic skewed burst, fixed expected table
    do_wr(0, 3'b111, 24'h030201); do_wr(1, 3'b111, 24'h060504);
    do_wr(2, 3'b111, 24'h090807); do_wr(3, 3'b111, 24'h0C0B0A);
    start_b(0, 4);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      chk($sformatf("t1_c%0d", t1[i].c), act_s(), t1[i].exp);
    end

    // reset during the third valid cycle, then an identical rerun
    start_b(0, 4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      chk("pre_rst_skew", act_s(), expv(1, c, 0, 4));
    end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_skew", act_s(), '0);
    chk("midrst_align", act_a(), '0);
    @(negedge clk);
    chk("midrst_hold", act_s(), '0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_idle", act_s(), '0);
    end
    run_burst(0, 4, 0);

    // address wrap
    do_wr(14, 3'b111, 24'hE1E2E3); do_wr(15, 3'b111, 24'hF1F2F3);
    do_wr(0, 3'b111, 24'h010203);  do_wr(1, 3'b111, 24'h111213);
    run_burst(14, 4, 0);

    // per-lane write mask
    do_wr(5, 3'b111, 24'hAABBCC);
    do_wr(5, 3'b010, 24'h112233);
    run_burst(5, 1, 0);
    chk("lane_wr", a_c2, mk(1, 1, 1, 24'hAA22CC));

    // len=0 ignored; start while busy ignored
    @(negedge clk); start = 1'b1; base_addr = 4'd3; len = 5'd0;
    @(negedge clk); start = 1'b0;
    chk("len0_skew", act_s(), '0);
    chk("len0_align", act_a(), '0);
    @(negedge clk);
    chk("len0_later", act_s(), '0);
    run_burst(0, 4, 1);

    // same-edge read/write: old data, then new data on re-read
    run_burst(0, 4, 2);
    run_burst(2, 1, 0);

    // full-depth burst and randomised traffic
    run_burst(9, 16, 0);
    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        do_wr(int'($urandom_range(0, 15)), 3'($urandom), 24'($urandom));
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(1, 16)),
                ($urandom_range(0, 2) == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
